// File: rtl/slider_attack_engine.sv
// Serial slider-attack generator: accepts one board job, then streams one attack
// bitboard per slider (lowest square first) together with a running union.
module slider_attack_engine #(
  parameter  int N    = 8,
  localparam int B    = N * N,
  localparam int SQ_W = $clog2(N * N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [B-1:0]    in_occupied,
  input  logic [B-1:0]    in_sliders,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SQ_W-1:0] out_square,
  output logic [B-1:0]    out_attacks,
  output logic [B-1:0]    out_union,
  output logic            out_last,
  output logic            out_empty
);

  typedef enum logic [1:0] {IDLE, RUN, EMPTY} state_t;

  state_t          state;
  logic [B-1:0]    occ_q;
  logic [B-1:0]    pending_q;
  logic [B-1:0]    acc_q;
  logic [1:0]      mode_q;

  logic            accept;
  logic [B-1:0]    pend_after;
  logic [B-1:0]    src_occ;
  logic [B-1:0]    src_pend;
  logic [B-1:0]    src_acc;
  logic [1:0]      src_mode;
  logic [SQ_W-1:0] next_sq;
  logic [B-1:0]    next_att;
  logic            next_last;

  // Walk every enabled ray from sq; a blocker is included and ends its ray.
  function automatic logic [B-1:0] ray_attacks(input logic [B-1:0]    occ,
                                               input logic [1:0]      mode,
                                               input logic [SQ_W-1:0] sq);
    logic [B-1:0]    att;
    logic [SQ_W-1:0] idx;
    logic            alive;
    int              r0, f0, r, f, dr, df;
    att = '0;
    idx = '0;
    r0  = int'(sq) / N;
    f0  = int'(sq) % N;
    for (int d = 0; d < 8; d++) begin
      case (d)
        0:       begin dr =  1; df =  0; end
        1:       begin dr = -1; df =  0; end
        2:       begin dr =  0; df =  1; end
        3:       begin dr =  0; df = -1; end
        4:       begin dr =  1; df =  1; end
        5:       begin dr =  1; df = -1; end
        6:       begin dr = -1; df =  1; end
        default: begin dr = -1; df = -1; end
      endcase
      alive = (d < 4) ? mode[0] : mode[1];
      r = r0;
      f = f0;
      for (int k = 1; k < N; k++) begin
        r = r + dr;
        f = f + df;
        if (r < 0 || r >= N || f < 0 || f >= N) alive = 1'b0;
        if (alive) begin
          idx      = SQ_W'(r * N + f);
          att[idx] = 1'b1;
          if (occ[idx]) alive = 1'b0;
        end
      end
    end
    return att;
  endfunction

  function automatic logic [SQ_W-1:0] lowest_square(input logic [B-1:0] v);
    logic [SQ_W-1:0] res;
    res = '0;
    for (int i = B - 1; i >= 0; i--) begin
      if (v[i]) res = SQ_W'(i);
    end
    return res;
  endfunction

  assign in_ready = (state == IDLE);

  // One generator serves both the first beat (fed from the job inputs) and every
  // following beat (fed from the latched job), so beats can be registered.
  always_comb begin
    accept     = (state == IDLE) && in_valid;
    pend_after = pending_q & (pending_q - B'(1));
    src_occ    = accept ? in_occupied : occ_q;
    src_mode   = accept ? in_mode     : mode_q;
    src_pend   = accept ? in_sliders  : pend_after;
    src_acc    = accept ? '0          : (acc_q | out_attacks);
    next_sq    = lowest_square(src_pend);
    next_att   = ray_attacks(src_occ, src_mode, next_sq);
    next_last  = ((src_pend & (src_pend - B'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      occ_q       <= '0;
      mode_q      <= '0;
      pending_q   <= '0;
      acc_q       <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_empty   <= 1'b0;
      out_square  <= '0;
      out_attacks <= '0;
      out_union   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            occ_q     <= in_occupied;
            mode_q    <= in_mode;
            pending_q <= in_sliders;
            acc_q     <= '0;
            out_valid <= 1'b1;
            if (in_sliders == '0) begin
              state       <= EMPTY;
              out_empty   <= 1'b1;
              out_last    <= 1'b1;
              out_square  <= '0;
              out_attacks <= '0;
              out_union   <= '0;
            end else begin
              state       <= RUN;
              out_empty   <= 1'b0;
              out_square  <= next_sq;
              out_attacks <= next_att;
              out_union   <= next_att;
              out_last    <= next_last;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            acc_q     <= src_acc;
            pending_q <= pend_after;
            if (out_last) begin
              state       <= IDLE;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              out_square  <= '0;
              out_attacks <= '0;
              out_union   <= '0;
            end else begin
              out_square  <= next_sq;
              out_attacks <= next_att;
              out_union   <= src_acc | next_att;
              out_last    <= next_last;
            end
          end
        end
        EMPTY: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_empty <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slider_attack_engine.sv
// Directed scoreboard bench for slider_attack_engine (8x8 main instance, 5x5 wrap check).
module tb_slider_attack_engine;

  typedef struct packed {
    logic [5:0]  sq;
    logic [63:0] att;
    logic [63:0] uni;
    logic        last;
    logic        empty;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_empty;
  logic [63:0] in_occupied, in_sliders, out_attacks, out_union;
  logic [1:0]  in_mode;
  logic [5:0]  out_square;

  logic        u5_in_valid, u5_in_ready, u5_out_valid, u5_out_ready, u5_out_last, u5_out_empty;
  logic [24:0] u5_in_occupied, u5_in_sliders, u5_out_attacks, u5_out_union;
  logic [1:0]  u5_in_mode;
  logic [4:0]  u5_out_square;

  beat_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;

  always #5 clk = ~clk;

  slider_attack_engine #(.N(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_occupied(in_occupied), .in_sliders(in_sliders), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_square(out_square), .out_attacks(out_attacks), .out_union(out_union),
    .out_last(out_last), .out_empty(out_empty)
  );

  slider_attack_engine #(.N(5)) dut5 (
    .clk(clk), .reset(reset),
    .in_valid(u5_in_valid), .in_ready(u5_in_ready),
    .in_occupied(u5_in_occupied), .in_sliders(u5_in_sliders), .in_mode(u5_in_mode),
    .out_valid(u5_out_valid), .out_ready(u5_out_ready),
    .out_square(u5_out_square), .out_attacks(u5_out_attacks), .out_union(u5_out_union),
    .out_last(u5_out_last), .out_empty(u5_out_empty)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic report_fail(input string tag);
    compared++;
    mismatched++;
    $error("[TB] FAIL %s observed=missing expected=beat", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [5:0] sq, input logic [63:0] att,
                           input logic [63:0] uni, input logic last, input logic empty);
    beat_t b;
    b.sq = sq; b.att = att; b.uni = uni; b.last = last; b.empty = empty;
    exp_q.push_back(b);
  endtask

  task automatic applyStimulus(input logic [63:0] occ, input logic [63:0] sliders,
                               input logic [1:0] mode);
    check_eq("in_ready_before_job", {63'd0, in_ready}, 64'd1);
    in_occupied = occ;
    in_sliders  = sliders;
    in_mode     = mode;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    in_occupied = $urandom();
    in_sliders  = {$urandom(), $urandom()};
    in_mode     = 2'($urandom());
  endtask

  // Samples mid-cycle; a beat offered and accepted is popped and compared.
  task automatic checkOutput(output bit taken);
    beat_t e;
    taken = 1'b0;
    @(negedge clk);
    if (out_valid && out_ready) begin
      taken = 1'b1;
      if (exp_q.size() == 0) begin
        report_fail("unexpected_beat");
      end else begin
        e = exp_q.pop_front();
        check_eq("beat_square",  {58'd0, out_square}, {58'd0, e.sq});
        check_eq("beat_attacks", out_attacks, e.att);
        check_eq("beat_union",   out_union, e.uni);
        check_eq("beat_last",    {63'd0, out_last}, {63'd0, e.last});
        check_eq("beat_empty",   {63'd0, out_empty}, {63'd0, e.empty});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    int cycles = 0;
    bit taken;
    while (exp_q.size() > 0 && cycles < 20) begin
      checkOutput(taken);
      cycles++;
    end
    if (exp_q.size() > 0) begin
      report_fail("drain_timeout");
      exp_q.delete();
    end
    check_eq("beat_cycles", 64'(cycles), 64'(n));
    check_eq("in_ready_after_job", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    out_ready      = 1'b1;
    in_occupied    = '0;
    in_sliders     = '0;
    in_mode        = 2'b00;
    u5_in_valid    = 1'b0;
    u5_out_ready   = 1'b1;
    u5_in_occupied = '0;
    u5_in_sliders  = '0;
    u5_in_mode     = 2'b00;
    step();
    step();
    check_eq("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_last",  {63'd0, out_last}, 64'd0);
    check_eq("rst_out_empty", {63'd0, out_empty}, 64'd0);
    check_eq("rst_square",    {58'd0, out_square}, 64'd0);
    check_eq("rst_attacks",   out_attacks, 64'd0);
    check_eq("rst_union",     out_union, 64'd0);
    reset = 1'b0;
    step();

    $display("[TB] rook d4 on empty board");
    push_beat(6'd27, 64'h08080808F7080808, 64'h08080808F7080808, 1'b1, 1'b0);
    applyStimulus(64'd0, 64'd1 << 27, 2'b01);
    drain(1);

    $display("[TB] bishop a1 on empty board");
    push_beat(6'd0, 64'h8040201008040200, 64'h8040201008040200, 1'b1, 1'b0);
    applyStimulus(64'd0, 64'd1, 2'b10);
    drain(1);

    // a2 (bit 8) and c1 (bit 2) block; the a1 occupancy bit is ignored.
    $display("[TB] rook a1 with blockers");
    push_beat(6'd0, 64'h0000000000000106, 64'h0000000000000106, 1'b1, 1'b0);
    applyStimulus(64'h0000000000010105, 64'd1, 2'b01);
    drain(1);

    $display("[TB] mode 00 still streams the square");
    push_beat(6'd10, 64'd0, 64'd0, 1'b1, 1'b0);
    applyStimulus(64'd0, 64'd1 << 10, 2'b00);
    drain(1);

    $display("[TB] two rooks corner to corner");
    push_beat(6'd0,  64'h01010101010101FE, 64'h01010101010101FE, 1'b0, 1'b0);
    push_beat(6'd63, 64'h7F80808080808080, 64'h7F818181818181FE, 1'b1, 1'b0);
    applyStimulus(64'd0, 64'h8000000000000001, 2'b01);
    drain(2);

    $display("[TB] backpressure on first beat");
    out_ready = 1'b0;
    push_beat(6'd0,  64'h01010101010101FE, 64'h01010101010101FE, 1'b0, 1'b0);
    push_beat(6'd63, 64'h7F80808080808080, 64'h7F818181818181FE, 1'b1, 1'b0);
    applyStimulus(64'd0, 64'h8000000000000001, 2'b01);
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_valid",    {63'd0, out_valid}, 64'd1);
      check_eq("stall_square",   {58'd0, out_square}, {58'd0, exp_q[0].sq});
      check_eq("stall_attacks",  out_attacks, exp_q[0].att);
      check_eq("stall_union",    out_union, exp_q[0].uni);
      check_eq("stall_last",     {63'd0, out_last}, 64'd0);
      check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain(2);

    $display("[TB] empty job");
    push_beat(6'd0, 64'd0, 64'd0, 1'b1, 1'b1);
    applyStimulus(64'h00FF00000000FF00, 64'd0, 2'b11);
    drain(1);

    $display("[TB] reset after first beat of three");
    begin
      bit taken;
      push_beat(6'd1, 64'h02020202020202FD, 64'h02020202020202FD, 1'b0, 1'b0);
      applyStimulus(64'd0, 64'h000000000000000E, 2'b01);
      checkOutput(taken);
      check_eq("first_beat_taken", {63'd0, taken}, 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("midrst_in_ready",  {63'd0, in_ready}, 64'd1);
      check_eq("midrst_union",     out_union, 64'd0);
      check_eq("midrst_last",      {63'd0, out_last}, 64'd0);
      step();
      check_eq("midrst_no_beat",   {63'd0, out_valid}, 64'd0);
    end

    $display("[TB] fresh job after reset starts a new union");
    push_beat(6'd27, 64'h08080808F7080808, 64'h08080808F7080808, 1'b1, 1'b0);
    applyStimulus(64'd0, 64'd1 << 27, 2'b01);
    drain(1);

    $display("[TB] 5x5 queen at centre");
    check_eq("n5_in_ready", {63'd0, u5_in_ready}, 64'd1);
    u5_in_occupied = 25'd0;
    u5_in_sliders  = 25'd1 << 12;
    u5_in_mode     = 2'b11;
    u5_in_valid    = 1'b1;
    step();
    u5_in_valid    = 1'b0;
    check_eq("n5_valid",   {63'd0, u5_out_valid}, 64'd1);
    check_eq("n5_square",  {59'd0, u5_out_square}, 64'd12);
    check_eq("n5_attacks", {39'd0, u5_out_attacks}, 64'h0000000001576DD5);
    check_eq("n5_union",   {39'd0, u5_out_union}, 64'h0000000001576DD5);
    check_eq("n5_last",    {63'd0, u5_out_last}, 64'd1);
    step();
    check_eq("n5_done",    {63'd0, u5_out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
